// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared definitions for the trap controller: FSM state enum,
//               exception source indices, cause width and the default trap
//               vector.
//               Optional feature macro: EXC_RET_EN (adds the ERET_RD state).
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

  // Exception source indices; a higher index wins the priority select.
  localparam int SRC_IF  = 0;
  localparam int SRC_ID  = 1;
  localparam int SRC_EX  = 2;
  localparam int SRC_MEM = 3;

  localparam int NUM_SRC = 4;
  localparam int CAUSE_W = 5;
  localparam int PC_W    = 32;

  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

  // Explicitly encoded 3-bit state. ERET_RD only exists when the
  // return-from-exception path is built in.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_SAVE     = 3'd2,
    ST_REDIRECT = 3'd3
`ifdef EXC_RET_EN
    ,
    ST_ERET_RD  = 3'd4
`endif
  } state_t;

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : trap_prio_sel
// Description : Combinational fixed-priority 4-to-1 select of exception
//               source (MEM > EX > ID > IF).
// Ports       : exc_valid  [3:0]   per-source request
//               exc_pc     [127:0] packed per-source PCs
//               exc_cause  [19:0]  packed per-source causes
//               any_valid          at least one source requesting
//               sel_pc     [31:0]  PC of the winning source
//               sel_cause  [4:0]   cause of the winning source
// Revision    : 1.0 - initial release
// ============================================================================
module trap_prio_sel
  import trap_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0]         exc_valid,
  input  logic [NUM_SRC*PC_W-1:0]    exc_pc,
  input  logic [NUM_SRC*CAUSE_W-1:0] exc_cause,
  output logic                       any_valid,
  output logic [PC_W-1:0]            sel_pc,
  output logic [CAUSE_W-1:0]         sel_cause
);

  always_comb begin
    any_valid = |exc_valid;
    sel_pc    = '0;
    sel_cause = '0;
    if (exc_valid[SRC_MEM]) begin
      sel_pc    = exc_pc[PC_W*SRC_MEM +: PC_W];
      sel_cause = exc_cause[CAUSE_W*SRC_MEM +: CAUSE_W];
    end else if (exc_valid[SRC_EX]) begin
      sel_pc    = exc_pc[PC_W*SRC_EX +: PC_W];
      sel_cause = exc_cause[CAUSE_W*SRC_EX +: CAUSE_W];
    end else if (exc_valid[SRC_ID]) begin
      sel_pc    = exc_pc[PC_W*SRC_ID +: PC_W];
      sel_cause = exc_cause[CAUSE_W*SRC_ID +: CAUSE_W];
    end else if (exc_valid[SRC_IF]) begin
      sel_pc    = exc_pc[PC_W*SRC_IF +: PC_W];
      sel_cause = exc_cause[CAUSE_W*SRC_IF +: CAUSE_W];
    end
  end

endmodule : trap_prio_sel
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Exception/trap sequencer. On an exception in IDLE it latches
//               the highest-priority source, flushes the pipeline for
//               FLUSH_CYCLES cycles, strobes the CSR write for one cycle and
//               then redirects fetch to TRAP_VECTOR until accepted.
//               Optional feature macro: EXC_RET_EN -- adds the
//               return-from-exception path (ERET_RD state, CSR read of EPC,
//               redirect to the EPC).
// Ports       : clk, reset (async, active-low)
//               exc_valid/exc_pc/exc_cause   per-source exception requests
//               eret_req/epc_in              exception return (EXC_RET_EN)
//               redirect_ready               fetch accepts redirect
//               exception_sig/_pc/_cause     CSR write strobe and data
//               csr_inst_on                  CSR read enable (EXC_RET_EN)
//               flush                        pipeline flush
//               redirect_valid/redirect_pc   redirect request to fetch
//               busy                         sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         exc_valid,
  input  logic [NUM_SRC*PC_W-1:0]    exc_pc,
  input  logic [NUM_SRC*CAUSE_W-1:0] exc_cause,
  input  logic                       eret_req,
  input  logic [PC_W-1:0]            epc_in,
  input  logic                       redirect_ready,
  output logic                       exception_sig,
  output logic [PC_W-1:0]            exception_pc,
  output logic [CAUSE_W-1:0]         exception_cause,
  output logic                       csr_inst_on,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [PC_W-1:0]            redirect_pc,
  output logic                       busy
);

  // Counter preload: the FLUSH state exits when the counter reaches zero,
  // so loading N-1 gives exactly N flush cycles.
  localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_flush_cnt;
  logic [PC_W-1:0]      r_lat_pc;
  logic [CAUSE_W-1:0]   r_lat_cause;
  logic [PC_W-1:0]      r_exc_pc;
  logic [CAUSE_W-1:0]   r_exc_cause;
  logic [PC_W-1:0]      r_redirect_pc;

  logic                 w_any_valid;
  logic [PC_W-1:0]      w_sel_pc;
  logic [CAUSE_W-1:0]   w_sel_cause;
  logic                 w_take_exc;

  trap_prio_sel u_prio (
    .exc_valid (exc_valid),
    .exc_pc    (exc_pc),
    .exc_cause (exc_cause),
    .any_valid (w_any_valid),
    .sel_pc    (w_sel_pc),
    .sel_cause (w_sel_cause)
  );

  // Requests are only looked at in IDLE; anything arriving later is dropped.
  assign w_take_exc = (r_state == ST_IDLE) && w_any_valid;

`ifndef EXC_RET_EN
  // Return path not built: these inputs are intentionally ignored.
  logic w_unused_eret;
  assign w_unused_eret = &{1'b0, eret_req, epc_in};
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // An exception beats a simultaneous return request.
        if (w_any_valid) begin
          w_state_nxt = ST_FLUSH;
        end
`ifdef EXC_RET_EN
        else if (eret_req) begin
          w_state_nxt = ST_ERET_RD;
        end
`endif
      end
      ST_FLUSH: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = ST_SAVE;
        end
      end
      ST_SAVE: begin
        w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef EXC_RET_EN
      ST_ERET_RD: begin
        w_state_nxt = ST_REDIRECT;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (strobes are pure functions of state)
  // --------------------------------------------------------------------------
  always_comb begin
    exception_sig  = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    csr_inst_on    = 1'b0;
    busy           = (r_state != ST_IDLE);
    case (r_state)
      ST_FLUSH:    flush          = 1'b1;
      ST_SAVE:     exception_sig  = 1'b1;
      ST_REDIRECT: redirect_valid = 1'b1;
`ifdef EXC_RET_EN
      ST_ERET_RD: begin
        csr_inst_on = 1'b1;
        flush       = 1'b1;
      end
`endif
      default: begin
        exception_sig = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: flush counter, latched source, held output registers.
  // Output registers load on the edge entering their active state so the
  // value is valid throughout that state and holds afterwards.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush_cnt   <= 4'd0;
      r_lat_pc      <= '0;
      r_lat_cause   <= '0;
      r_exc_pc      <= '0;
      r_exc_cause   <= '0;
      r_redirect_pc <= '0;
    end else begin
      if (w_take_exc) begin
        r_flush_cnt <= c_flush_load;
        r_lat_pc    <= w_sel_pc;
        r_lat_cause <= w_sel_cause;
      end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 4'd0)) begin
        r_flush_cnt <= r_flush_cnt - 4'd1;
      end

      if ((r_state == ST_FLUSH) && (w_state_nxt == ST_SAVE)) begin
        r_exc_pc    <= r_lat_pc;
        r_exc_cause <= r_lat_cause;
      end

      if (r_state == ST_SAVE) begin
        r_redirect_pc <= TRAP_VECTOR;
      end
`ifdef EXC_RET_EN
      else if (r_state == ST_ERET_RD) begin
        // EPC read from the CSR block during the single ERET_RD cycle.
        r_redirect_pc <= epc_in;
      end
`endif
    end
  end

  assign exception_pc    = r_exc_pc;
  assign exception_cause = r_exc_cause;
  assign redirect_pc     = r_redirect_pc;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl with default
//               parameters (TRAP_VECTOR = 32'h100, FLUSH_CYCLES = 2).
//               Return-path scenarios compile in with EXC_RET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic         clk;
  logic         reset;
  logic [3:0]   exc_valid;
  logic [127:0] exc_pc;
  logic [19:0]  exc_cause;
  logic         eret_req;
  logic [31:0]  epc_in;
  logic         redirect_ready;
  logic         exception_sig;
  logic [31:0]  exception_pc;
  logic [4:0]   exception_cause;
  logic         csr_inst_on;
  logic         flush;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  trap_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .exc_valid       (exc_valid),
    .exc_pc          (exc_pc),
    .exc_cause       (exc_cause),
    .eret_req        (eret_req),
    .epc_in          (epc_in),
    .redirect_ready  (redirect_ready),
    .exception_sig   (exception_sig),
    .exception_pc    (exception_pc),
    .exception_cause (exception_cause),
    .csr_inst_on     (csr_inst_on),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [31:0] pc, input logic [4:0] cause);
    exc_pc[32*idx +: 32]   = pc;
    exc_cause[5*idx +: 5]  = cause;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    exc_valid = 4'b0; exc_pc = '0; exc_cause = '0;
    eret_req = 1'b0; epc_in = '0; redirect_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || flush !== 1'b0 || exception_sig !== 1'b0 || redirect_valid !== 1'b0 || csr_inst_on !== 1'b0) begin
      n_err++;
      $display("FAIL reset_strobes got busy=%b flush=%b sig=%b rv=%b csr=%b want all 0", busy, flush, exception_sig, redirect_valid, csr_inst_on);
    end
    n_cmp++;
    if (exception_pc !== 32'h0 || exception_cause !== 5'h0 || redirect_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data got epc=%h cause=%h rpc=%h want 0", exception_pc, exception_cause, redirect_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Scenario 1: single ID exception, full sequence timing
  task automatic test_single();
    set_src(1, 32'h40, 5'd2);
    exc_valid = 4'b0010;
    redirect_ready = 1'b1;
    tick(); // cycle 1
    exc_valid = 4'b0;
    n_cmp++;
    if (flush !== 1'b1 || busy !== 1'b1 || exception_sig !== 1'b0) begin
      n_err++;
      $display("FAIL s1_c1 got flush=%b busy=%b sig=%b want 1 1 0", flush, busy, exception_sig);
    end
    tick(); // cycle 2
    n_cmp++;
    if (flush !== 1'b1 || exception_sig !== 1'b0) begin
      n_err++;
      $display("FAIL s1_c2 got flush=%b sig=%b want 1 0", flush, exception_sig);
    end
    tick(); // cycle 3
    n_cmp++;
    if (flush !== 1'b0 || exception_sig !== 1'b1 || exception_pc !== 32'h40 || exception_cause !== 5'd2 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL s1_c3 got flush=%b sig=%b pc=%h cause=%0d rv=%b want 0 1 40 2 0", flush, exception_sig, exception_pc, exception_cause, redirect_valid);
    end
    tick(); // cycle 4
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100 || exception_sig !== 1'b0) begin
      n_err++;
      $display("FAIL s1_c4 got rv=%b rpc=%h sig=%b want 1 100 0", redirect_valid, redirect_pc, exception_sig);
    end
    tick(); // cycle 5
    n_cmp++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || exception_pc !== 32'h40 || redirect_pc !== 32'h100) begin
      n_err++;
      $display("FAIL s1_c5 got busy=%b rv=%b epc=%h rpc=%h want 0 0 40 100", busy, redirect_valid, exception_pc, redirect_pc);
    end
  endtask

  // Scenario 2 plus extra priority patterns
  task automatic test_priority();
    logic [3:0]  vec [3];
    logic [31:0] exp_pc [3];
    logic [4:0]  exp_cause [3];
    set_src(0, 32'h8C, 5'd1);
    set_src(1, 32'h94, 5'd9);
    set_src(2, 32'h98, 5'd12);
    set_src(3, 32'h80, 5'd5);
    vec[0] = 4'b1001; exp_pc[0] = 32'h80; exp_cause[0] = 5'd5;
    vec[1] = 4'b0110; exp_pc[1] = 32'h98; exp_cause[1] = 5'd12;
    vec[2] = 4'b0001; exp_pc[2] = 32'h8C; exp_cause[2] = 5'd1;
    for (int i = 0; i < 3; i++) begin
      exc_valid = vec[i];
      tick();
      exc_valid = 4'b0;
      tick(); tick(); // SAVE cycle
      n_cmp++;
      if (exception_sig !== 1'b1 || exception_pc !== exp_pc[i] || exception_cause !== exp_cause[i]) begin
        n_err++;
        $display("FAIL prio_%0d got sig=%b pc=%h cause=%0d want 1 %h %0d", i, exception_sig, exception_pc, exception_cause, exp_pc[i], exp_cause[i]);
      end
      tick(); tick();
    end
  endtask

  // Scenario 3: redirect back-pressure; second exception ignored
  task automatic test_backpressure();
    set_src(2, 32'h200, 5'd7);
    set_src(3, 32'h300, 5'd3);
    exc_valid = 4'b0100;
    redirect_ready = 1'b0;
    tick();
    exc_valid = 4'b0;
    tick(); tick(); tick(); // cycle 4: REDIRECT
    exc_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100 || flush !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d got rv=%b rpc=%h flush=%b want 1 100 0", i, redirect_valid, redirect_pc, flush);
      end
      if (i < 2) tick();
    end
    redirect_ready = 1'b1;
    exc_valid = 4'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || exception_pc !== 32'h200 || exception_cause !== 5'd7) begin
      n_err++;
      $display("FAIL bp_release got busy=%b rv=%b pc=%h cause=%0d want 0 0 200 7", busy, redirect_valid, exception_pc, exception_cause);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_queue got busy=%b want 0", busy);
    end
  endtask

  // Scenario 4: asynchronous reset mid-FLUSH
  task automatic test_async_reset();
    set_src(0, 32'h500, 5'd4);
    exc_valid = 4'b0001;
    tick();
    exc_valid = 4'b0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || flush !== 1'b0 || exception_pc !== 32'h0 || exception_cause !== 5'h0 || redirect_pc !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst got busy=%b flush=%b pc=%h cause=%h rpc=%h want all 0", busy, flush, exception_pc, exception_cause, redirect_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || flush !== 1'b0) begin
        n_err++;
        $display("FAIL post_rst_%0d got busy=%b flush=%b want 0 0", i, busy, flush);
      end
    end
  endtask

`ifdef EXC_RET_EN
  // Scenario 5: return from exception
  task automatic test_eret();
    redirect_ready = 1'b1;
    eret_req = 1'b1;
    epc_in = 32'h40;
    tick(); // ERET_RD
    eret_req = 1'b0;
    n_cmp++;
    if (csr_inst_on !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL eret_rd got csr=%b flush=%b rv=%b want 1 1 0", csr_inst_on, flush, redirect_valid);
    end
    tick(); // REDIRECT
    epc_in = 32'hDEAD_0000;
    n_cmp++;
    if (csr_inst_on !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h40) begin
      n_err++;
      $display("FAIL eret_redir got csr=%b flush=%b rv=%b rpc=%h want 0 0 1 40", csr_inst_on, flush, redirect_valid, redirect_pc);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || redirect_pc !== 32'h40) begin
      n_err++;
      $display("FAIL eret_done got busy=%b rpc=%h want 0 40", busy, redirect_pc);
    end
  endtask

  // Scenario 6: exception beats eret
  task automatic test_eret_vs_exc();
    int csr_seen = 0;
    set_src(2, 32'h300, 5'd3);
    eret_req = 1'b1;
    epc_in = 32'h40;
    exc_valid = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      tick();
      eret_req = 1'b0;
      exc_valid = 4'b0;
      if (csr_inst_on !== 1'b0) csr_seen++;
      if (c == 3) begin
        n_cmp++;
        if (exception_sig !== 1'b1 || exception_pc !== 32'h300 || exception_cause !== 5'd3) begin
          n_err++;
          $display("FAIL exc_wins_save got sig=%b pc=%h cause=%0d want 1 300 3", exception_sig, exception_pc, exception_cause);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
          n_err++;
          $display("FAIL exc_wins_redir got rv=%b rpc=%h want 1 100", redirect_valid, redirect_pc);
        end
      end
    end
    n_cmp++;
    if (csr_seen != 0) begin
      n_err++;
      $display("FAIL exc_wins_csr got %0d cycles with csr_inst_on want 0", csr_seen);
    end
    tick();
  endtask
`else
  // Return path absent: eret_req must be ignored and csr_inst_on stay 0
  task automatic test_eret_disabled();
    eret_req = 1'b1;
    epc_in = 32'h40;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || csr_inst_on !== 1'b0 || flush !== 1'b0) begin
      n_err++;
      $display("FAIL eret_off got busy=%b csr=%b flush=%b want 0 0 0", busy, csr_inst_on, flush);
    end
    eret_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_async_reset();
`ifdef EXC_RET_EN
    test_eret();
    test_eret_vs_exc();
`else
    test_eret_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_trap_ctrl
`default_nettype wire
